// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter among packet requesters
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_dv,
    output logic [7:0]           tx_byte,
    input  logic                 tx_done,
    output logic [2:0]           grant_id,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;
    state_t     state_q, state_d;
    logic [2:0] grant_q, grant_d, rr_q, rr_d, pick;
    logic [7:0] cnt_q, cnt_d, byte_q, byte_d, cur_byte;
    logic       dv_q, dv_d, last_q, last_d, cur_valid, cur_last;
    int         best;
    // pick the valid requester closest to rr_q going upward with wrap
    always_comb begin
        pick = '0;
        best = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && ((i - int'(rr_q) + NUM_REQ) % NUM_REQ) < best) begin
                best = (i - int'(rr_q) + NUM_REQ) % NUM_REQ;
                pick = 3'(i);
            end
        end
    end
    // route the granted requester's stream and ready
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_byte  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 3'(i)) begin
                cur_valid    = req_valid[i];
                cur_last     = req_last[i];
                cur_byte     = req_data[8*i +: 8];
                req_ready[i] = (state_q == SEND);
            end
        end
    end
    // next-state: grant in IDLE, accept in SEND, release or continue on tx_done
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        last_d  = last_q;
        dv_d    = 1'b0;
        if (state_q == IDLE) begin
            if (|req_valid) begin
                grant_d = pick;
                cnt_d   = '0;
                state_d = SEND;
            end
        end else if (state_q == SEND) begin
            if (cur_valid) begin
                byte_d  = cur_byte;
                dv_d    = 1'b1;
                last_d  = cur_last;
                cnt_d   = cnt_q + 8'd1;
                state_d = WAIT_DONE;
            end
        end else if (tx_done) begin
            if (last_q || cnt_q == 8'(MAX_PKT_LEN)) begin
                rr_d    = (grant_q == 3'(NUM_REQ-1)) ? 3'd0 : grant_q + 3'd1;
                state_d = IDLE;
            end else begin
                state_d = SEND;
            end
        end
    end
    // state registers; reset aborts any packet in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            dv_q    <= dv_d;
        end
    end
    assign tx_dv    = dv_q;
    assign tx_byte  = byte_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random packet streams checked against a packet-level round-robin model
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int MAXL = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic tx_dv, busy;
    logic tx_done = 1'b0;
    logic [7:0] tx_byte;
    logic [2:0] grant_id;
    int errors = 0, checks = 0;
    logic [8:0] rq [N][$];
    logic [8:0] mq [N][$];
    logic [10:0] obs[$], expq[$];
    int mrr = 0, dcnt = 0, lat = 10;
    logic spur = 1'b0, prev_dv = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_PKT_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic drive();
        logic [8:0] e;
        for (int i = 0; i < N; i++) begin
            e = (rq[i].size() > 0) ? rq[i][0] : 9'd0;
            req_valid[i] = (rq[i].size() > 0);
            req_data[8*i +: 8] = e[7:0];
            req_last[i] = e[8];
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l, input bit to_rq);
        mq[r].push_back({l, d});
        if (to_rq) rq[r].push_back({l, d});
    endtask

    // reference: serve whole packets (capped at MAXL bytes) in round-robin order from mrr
    task automatic model_run();
        int id;
        logic [8:0] e;
        while (1) begin
            id = -1;
            for (int k = 0; k < N; k++) if (id < 0 && mq[(mrr+k)%N].size() > 0) id = (mrr+k)%N;
            if (id < 0) break;
            for (int n = 0; n < MAXL && mq[id].size() > 0; n++) begin
                e = mq[id].pop_front();
                expq.push_back({3'(id), e[7:0]});
                if (e[8]) break;
            end
            mrr = (id + 1) % N;
        end
    endtask

    // one clock: handshake pops, transmitter model, per-cycle invariants
    task automatic tick();
        logic [N-1:0] acc;
        logic fire;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) void'(rq[i].pop_front());
        fire = 1'b0;
        if (dcnt > 0) begin
            dcnt--;
            fire = (dcnt == 0);
        end
        if (tx_dv) begin
            obs.push_back({grant_id, tx_byte});
            dcnt = lat;
            chk("dv_pulse", 32'(prev_dv), 0);
        end
        prev_dv = tx_dv;
        tx_done = fire | spur;
        chk("ready_only_grant", 32'(req_ready & ~(N'(1) << grant_id)), 0);
        drive();
    endtask

    task automatic wait_obs(input int n, input bit need_done);
        int t = 0;
        while (!(obs.size() >= n && (!need_done || tx_done)) && t < 3000) begin
            tick();
            t++;
        end
        chk("wait_obs", 32'(t < 3000), 1);
    endtask

    task automatic wait_all();
        int t = 0;
        while (!(obs.size() >= expq.size() && !busy && dcnt == 0) && t < 3000) begin
            tick();
            t++;
        end
        chk("wait_all", 32'(t < 3000), 1);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, 32'(obs.size()), 32'(expq.size()));
        for (int i = 0; i < obs.size() && i < expq.size(); i++) chk({tag, "_byte"}, 32'(obs[i]), 32'(expq[i]));
        obs.delete();
        expq.delete();
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            mq[i].delete();
        end
        mrr = 0;
        dcnt = 0;
        spur = 1'b0;
        prev_dv = 1'b0;
        tx_done = 1'b0;
        drive();
    endtask

    initial begin
        clear_all();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dv", 32'(tx_dv), 0);
        chk("rst_byte", 32'(tx_byte), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst = 1'b0;
        // single packet with latency checks
        push(0, 8'h41, 1'b0, 1);
        push(0, 8'h42, 1'b0, 1);
        push(0, 8'h43, 1'b1, 1);
        model_run();
        drive();
        tick();
        chk("lat_busy", 32'(busy), 1);
        chk("lat_ready", 32'(req_ready), 32'h1);
        tick();
        chk("lat_dv", 32'(tx_dv), 1);
        chk("lat_byte", 32'(tx_byte), 32'h41);
        wait_obs(3, 1);
        chk("busy_at_done", 32'(busy), 1);
        tick();
        chk("busy_after_done", 32'(busy), 0);
        wait_all();
        compare("single");
        // rr now past req0: req1 should win over req0
        push(0, 8'h50, 1'b1, 1);
        push(1, 8'h51, 1'b1, 1);
        model_run();
        drive();
        tick();
        chk("rr_after_single", 32'(grant_id), 1);
        wait_all();
        compare("rr1");
        // reset, then simultaneous requests over two rounds
        rst = 1'b1;
        clear_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            push(0, 8'h10, 1'b1, 1);
            push(2, 8'h20, 1'b1, 1);
            model_run();
            drive();
            wait_all();
            compare("contend");
        end
        // no interleave: req3 arrives during req1's second byte
        for (int b = 0; b < 4; b++) push(1, 8'(8'h30 + b), b == 3, 1);
        model_run();
        drive();
        wait_obs(2, 0);
        for (int b = 0; b < 3; b++) push(3, 8'($urandom), b == 2, 1);
        model_run();
        drive();
        chk("no_ready_req3", 32'(req_ready[3]), 0);
        chk("grant_req1", 32'(grant_id), 1);
        wait_all();
        compare("nointerleave");
        // forced release after MAXL bytes
        for (int b = 0; b < 6; b++) push(0, 8'(8'h60 + b), b == 5, 1);
        push(1, 8'h70, 1'b0, 1);
        push(1, 8'h71, 1'b1, 1);
        model_run();
        drive();
        wait_all();
        compare("forced");
        // stall in SEND with spurious tx_done
        push(2, 8'h81, 1'b0, 1);
        push(2, 8'h82, 1'b0, 0);
        push(2, 8'h83, 1'b1, 0);
        model_run();
        drive();
        wait_obs(1, 1);
        tick();
        for (int k = 0; k < 20; k++) begin
            spur = k[0];
            tick();
            chk("stall_dv", 32'(tx_dv), 0);
            chk("stall_busy", 32'(busy), 1);
            chk("stall_ready", 32'(req_ready), 32'h4);
        end
        spur = 1'b0;
        rq[2].push_back({1'b0, 8'h82});
        rq[2].push_back({1'b1, 8'h83});
        drive();
        wait_all();
        compare("stall");
        // async reset during the tx_dv cycle of a packet
        push(0, 8'h91, 1'b0, 1);
        push(0, 8'h92, 1'b1, 1);
        model_run();
        drive();
        wait_obs(1, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_dv", 32'(tx_dv), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(req_ready), 0);
        chk("arst_grant", 32'(grant_id), 0);
        while (expq.size() > obs.size()) void'(expq.pop_back());
        compare("aborted");
        clear_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(0, 8'hA0, 1'b1, 1);
        push(3, 8'hA3, 1'b1, 1);
        model_run();
        drive();
        tick();
        chk("post_rst_grant", 32'(grant_id), 0);
        wait_all();
        compare("post_rst");
        // random packets on all requesters, random transmitter latency
        for (int r = 0; r < 4; r++) begin
            lat = $urandom_range(1, 12);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1 || i == r) begin
                    int len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1, 1);
                end
            end
            model_run();
            drive();
            wait_all();
            compare("random");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
